// File: rtl/udp.sv
// Streaming UDP payload extractor: input FIFO -> Ethernet/IPv4/UDP header parser -> FWFT output FIFO.
// Optional IPv4 header checksum verification is enabled by defining IPV4_CHECKSUM_EN.
module udp #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] in_din,
    input  logic       in_wr_en,
    input  logic       in_wr_sof,
    input  logic       in_wr_eof,
    output logic       in_full,
    input  logic       out_rd_en,
    output logic       out_rd_sof,
    output logic       out_rd_eof,
    output logic [7:0] out_dout,
    output logic       out_empty
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StEthHdr, StIpHdr, StUdpHdr, StPayload, StDrain} state_e;

    // Input FIFO; entry = {sof, eof, byte}, pointers carry an extra wrap bit.
    logic [9:0]  in_mem [FIFO_DEPTH];
    logic [AW:0] in_wptr_q, in_rptr_q;
    logic        in_empty, in_push, in_pop;
    logic        hd_sof, hd_eof;
    logic [7:0]  hd_byte;

    assign in_empty = (in_wptr_q == in_rptr_q);
    assign in_full  = (in_wptr_q[AW] != in_rptr_q[AW]) &&
                      (in_wptr_q[AW-1:0] == in_rptr_q[AW-1:0]);
    assign in_push  = in_wr_en && !in_full;
    assign {hd_sof, hd_eof, hd_byte} = in_mem[in_rptr_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (in_push) in_mem[in_wptr_q[AW-1:0]] <= {in_wr_sof, in_wr_eof, in_din};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_wptr_q <= '0;
            in_rptr_q <= '0;
        end else begin
            if (in_push) in_wptr_q <= in_wptr_q + 1'b1;
            if (in_pop)  in_rptr_q <= in_rptr_q + 1'b1;
        end
    end

    // Output FIFO, first-word-fall-through.
    logic [9:0]  out_mem [FIFO_DEPTH];
    logic [AW:0] out_wptr_q, out_rptr_q;
    logic        out_full, out_push, out_pop;
    logic [9:0]  out_wdata, out_head;

    assign out_empty = (out_wptr_q == out_rptr_q);
    assign out_full  = (out_wptr_q[AW] != out_rptr_q[AW]) &&
                       (out_wptr_q[AW-1:0] == out_rptr_q[AW-1:0]);
    assign out_pop   = out_rd_en && !out_empty;
    assign out_head  = out_empty ? 10'd0 : out_mem[out_rptr_q[AW-1:0]];
    assign {out_rd_sof, out_rd_eof, out_dout} = out_head;

    always_ff @(posedge clock) begin
        if (out_push) out_mem[out_wptr_q[AW-1:0]] <= out_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_wptr_q <= '0;
            out_rptr_q <= '0;
        end else begin
            if (out_push) out_wptr_q <= out_wptr_q + 1'b1;
            if (out_pop)  out_rptr_q <= out_rptr_q + 1'b1;
        end
    end

    // Parser state
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, len_q, len_d, rem_q, rem_d;
    logic [7:0]  hi_q, hi_d;
    logic        ip_ok_q, ip_ok_d, first_q, first_d, csum_ok;

`ifdef IPV4_CHECKSUM_EN
    logic [15:0] sum_q, sum_d, sum_next;
    logic [16:0] sum_raw;

    // One's-complement accumulate with end-around carry.
    assign sum_raw  = {1'b0, sum_q} + {1'b0, hi_q, hd_byte};
    assign sum_next = sum_raw[15:0] + {15'd0, sum_raw[16]};
    assign csum_ok  = (sum_next == 16'hFFFF);

    always_ff @(posedge clock) begin
        if (reset) sum_q <= '0;
        else       sum_q <= sum_d;
    end
`else
    assign csum_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            ip_ok_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            ip_ok_q <= ip_ok_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        ip_ok_d   = ip_ok_q;
        first_d   = first_q;
`ifdef IPV4_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        out_push  = 1'b0;
        out_wdata = {first_q, hd_eof || (rem_q == 16'd1), hd_byte};
        in_pop    = !in_empty && (state_q != StPayload || !out_full);

        if (in_pop) begin
            if (hd_sof) begin
                // Any sof restarts parsing; a lone sof+eof byte is just dropped.
                state_d = hd_eof ? StIdle : StEthHdr;
                cnt_d   = 16'd1;
            end else begin
                cnt_d = cnt_q + 16'd1;
                unique case (state_q)
                    StEthHdr: begin
                        if (cnt_q == 16'd12) hi_d = hd_byte;
                        if (hd_eof) begin
                            state_d = StIdle;
                        end else if (cnt_q == 16'd13) begin
                            state_d = ({hi_q, hd_byte} == 16'h0800) ? StIpHdr : StDrain;
                            cnt_d   = '0;
`ifdef IPV4_CHECKSUM_EN
                            sum_d   = '0;
`endif
                        end
                    end
                    StIpHdr: begin
                        if (!cnt_q[0]) hi_d = hd_byte;
`ifdef IPV4_CHECKSUM_EN
                        else sum_d = sum_next;
`endif
                        if (cnt_q == 16'd0) ip_ok_d = (hd_byte == 8'h45);
                        if (cnt_q == 16'd9) ip_ok_d = ip_ok_q && (hd_byte == 8'h11);
                        if (hd_eof) begin
                            state_d = StIdle;
                        end else if (cnt_q == 16'd19) begin
                            state_d = (ip_ok_q && csum_ok) ? StUdpHdr : StDrain;
                            cnt_d   = '0;
                        end
                    end
                    StUdpHdr: begin
                        if (cnt_q == 16'd4) hi_d = hd_byte;
                        if (cnt_q == 16'd5) len_d = {hi_q, hd_byte};
                        if (hd_eof) begin
                            state_d = StIdle;
                        end else if (cnt_q == 16'd7) begin
                            // L <= 8 means no payload at all.
                            state_d = (len_q <= 16'd8) ? StDrain : StPayload;
                            rem_d   = len_q - 16'd8;
                            first_d = 1'b1;
                        end
                    end
                    StPayload: begin
                        out_push = 1'b1;
                        first_d  = 1'b0;
                        rem_d    = rem_q - 16'd1;
                        if (hd_eof)                 state_d = StIdle;
                        else if (rem_q == 16'd1)    state_d = StDrain;
                    end
                    StIdle, StDrain: begin
                        if (hd_eof) state_d = StIdle;
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udp.sv
// Randomized scoreboard bench for udp: frames are generated, a frame-level reference model
// predicts the payload stream, and a monitor compares every popped output byte.
module tb_udp;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] in_din;
    logic       in_wr_en, in_wr_sof, in_wr_eof, in_full;
    logic       out_rd_en, out_rd_sof, out_rd_eof, out_empty;
    logic [7:0] out_dout;

    always #5 clock = ~clock;

    udp dut (
        .clock     (clock),
        .reset     (reset),
        .in_din    (in_din),
        .in_wr_en  (in_wr_en),
        .in_wr_sof (in_wr_sof),
        .in_wr_eof (in_wr_eof),
        .in_full   (in_full),
        .out_rd_en (out_rd_en),
        .out_rd_sof(out_rd_sof),
        .out_rd_eof(out_rd_eof),
        .out_dout  (out_dout),
        .out_empty (out_empty)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         popped = 0;
    int         rd_mode = 0;  // 0: hold low, 1: always read, 2: random
    logic [9:0] exp_q[$];     // {sof, eof, byte}
    logic [7:0] fr[$];
    logic [7:0] pl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model: whole-frame view of which bytes are the UDP payload.
    function automatic void model_frame();
        int n, p, k;
        logic [31:0] s;
        n = fr.size();
        if (n < 43) return;
        if ({fr[12], fr[13]} != 16'h0800) return;
        if (fr[14] != 8'h45 || fr[23] != 8'h11) return;
`ifdef IPV4_CHECKSUM_EN
        s = 0;
        for (int w = 0; w < 10; w++) s += {16'd0, fr[14 + 2*w], fr[15 + 2*w]};
        s = (s & 32'hFFFF) + (s >> 16);
        s = (s & 32'hFFFF) + (s >> 16);
        if (s != 32'hFFFF) return;
`else
        s = 0;
`endif
        p = int'({fr[38], fr[39]}) - 8;
        if (p <= 0) return;
        k = (p < n - 42) ? p : n - 42;
        for (int i = 0; i < k; i++)
            exp_q.push_back({i == 0, i == k - 1, fr[42 + i]});
    endfunction

    task automatic make_frame(input logic [15:0] etype, input logic [7:0] vihl,
                              input logic [7:0] proto, input logic [15:0] ulen,
                              input int pad, input bit bad);
        logic [31:0] s;
        fr.delete();
        for (int i = 0; i < 12; i++) fr.push_back(8'($urandom));
        fr.push_back(etype[15:8]); fr.push_back(etype[7:0]);
        fr.push_back(vihl); fr.push_back(8'h00);
        fr.push_back(8'h00); fr.push_back(8'(28 + pl.size()));
        fr.push_back(8'($urandom)); fr.push_back(8'($urandom));
        fr.push_back(8'h00); fr.push_back(8'h00);
        fr.push_back(8'h40); fr.push_back(proto);
        fr.push_back(8'h00); fr.push_back(8'h00);
        for (int i = 0; i < 8; i++) fr.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) fr.push_back(8'($urandom));
        fr.push_back(ulen[15:8]); fr.push_back(ulen[7:0]);
        fr.push_back(8'h00); fr.push_back(8'h00);
        foreach (pl[i]) fr.push_back(pl[i]);
        for (int i = 0; i < pad; i++) fr.push_back(8'($urandom));
        s = 0;
        for (int w = 0; w < 10; w++) s += {16'd0, fr[14 + 2*w], fr[15 + 2*w]};
        s = (s & 32'hFFFF) + (s >> 16);
        s = (s & 32'hFFFF) + (s >> 16);
        s = ~s;
        fr[24] = s[15:8];
        fr[25] = s[7:0];
        if (bad) fr[24] = fr[24] ^ 8'h5A;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic s, input logic e);
        int t = 0;
        @(negedge clock);
        while (in_full) begin
            in_wr_en = 1'b0;
            @(negedge clock);
            t++;
            if (t > 5000) begin
                $display("FAIL in_full_timeout: got stuck full, expected drain");
                miscompares++;
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $fatal(1, "input never drained");
            end
        end
        in_din = b; in_wr_sof = s; in_wr_eof = e; in_wr_en = 1'b1;
    endtask

    task automatic send_frame();
        model_frame();
        foreach (fr[i]) send_byte(fr[i], i == 0, i == fr.size() - 1);
    endtask

    task automatic idle(input int n);
        @(negedge clock);
        in_wr_en = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic set_payload(input string s);
        pl.delete();
        for (int i = 0; i < s.len(); i++) pl.push_back(s[i]);
    endtask

    task automatic rand_payload(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    // Monitor: decides read strobe each cycle and checks every popped byte.
    initial begin
        out_rd_en = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                out_rd_en = 1'b0;
            end else begin
                case (rd_mode)
                    0:       out_rd_en = 1'b0;
                    1:       out_rd_en = 1'b1;
                    default: out_rd_en = 1'($urandom_range(0, 1));
                endcase
                if (out_rd_en && !out_empty) begin
                    popped++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_output: got %h, expected nothing",
                                 {out_rd_sof, out_rd_eof, out_dout});
                    end else begin
                        check("payload", {22'd0, out_rd_sof, out_rd_eof, out_dout},
                              {22'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        int base, t;
        reset = 1'b1; in_din = '0; in_wr_en = 1'b0; in_wr_sof = 1'b0; in_wr_eof = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_out_empty", out_empty, 1);
        check("reset_in_full", in_full, 0);
        check("reset_out_dout", out_dout, 0);
        check("reset_out_sof_eof", {out_rd_sof, out_rd_eof}, 0);
        rd_mode = 1;
        repeat (20) @(negedge clock);
        check("idle_out_empty", out_empty, 1);

        // "Hello" with 4 padding bytes.
        set_payload("Hello");
        make_frame(16'h0800, 8'h45, 8'h11, 16'h000D, 4, 0);
        send_frame();
        idle(3);

        // TCP frame dropped, then "AB".
        set_payload("XYZW");
        make_frame(16'h0800, 8'h45, 8'h06, 16'h000C, 2, 0);
        send_frame();
        set_payload("AB");
        make_frame(16'h0800, 8'h45, 8'h11, 16'h000A, 0, 0);
        send_frame();
        idle(3);

        // Truncated datagram, then a normal one.
        set_payload("xyz");
        make_frame(16'h0800, 8'h45, 8'h11, 16'h0010, 0, 0);
        send_frame();
        set_payload("ok");
        make_frame(16'h0800, 8'h45, 8'h11, 16'h000A, 6, 0);
        send_frame();

        // Degenerate cases: lone byte frame, stray non-sof bytes, L<8, L==8.
        send_byte(8'hAA, 1, 1);
        send_byte(8'h55, 0, 0);
        send_byte(8'h66, 0, 1);
        rand_payload(4);
        make_frame(16'h0800, 8'h45, 8'h11, 16'h0005, 0, 0);
        send_frame();
        pl.delete();
        make_frame(16'h0800, 8'h45, 8'h11, 16'h0008, 4, 0);
        send_frame();
        set_payload("Z");
        make_frame(16'h0800, 8'h45, 8'h11, 16'h0009, 0, 0);
        send_frame();
        idle(30);
        check("directed_drained", exp_q.size(), 0);

`ifdef IPV4_CHECKSUM_EN
        set_payload("bad");
        make_frame(16'h0800, 8'h45, 8'h11, 16'h000B, 0, 1);
        send_frame();
        set_payload("good");
        make_frame(16'h0800, 8'h45, 8'h11, 16'h000C, 0, 0);
        send_frame();
        idle(30);
`endif

        // Backpressure: 40-byte payload with reads held off.
        rd_mode = 0;
        rand_payload(40);
        make_frame(16'h0800, 8'h45, 8'h11, 16'd48, 0, 0);
        fork
            send_frame();
            begin
                repeat (150) @(negedge clock);
                check("backpressure_in_full", in_full, 1);
                check("backpressure_no_output_yet", exp_q.size(), 40);
                @(posedge clock);
                base = popped;
                rd_mode = 1;
                repeat (40) @(negedge clock);
                #1;
                check("burst_one_per_cycle", popped - base, 40);
            end
        join
        idle(5);

        // Randomized frames.
        rd_mode = 2;
        for (int k = 0; k < 40; k++) begin
            logic [15:0] et, ul;
            logic [7:0]  vi, pr;
            int          n;
            et = ($urandom_range(0, 99) < 8) ? 16'h86DD : 16'h0800;
            vi = ($urandom_range(0, 99) < 8) ? 8'h46 : 8'h45;
            pr = ($urandom_range(0, 99) < 8) ? 8'h06 : 8'h11;
            rand_payload($urandom_range(0, 30));
            ul = ($urandom_range(0, 99) < 10) ? 16'($urandom_range(0, 8))
                                              : 16'(8 + $urandom_range(1, 25));
            make_frame(et, vi, pr, ul, $urandom_range(0, 5), $urandom_range(0, 99) < 10);
            if ($urandom_range(0, 99) < 10) begin
                n = $urandom_range(1, fr.size());
                while (fr.size() > n) void'(fr.pop_back());
            end
            if ($urandom_range(0, 99) < 15)
                repeat ($urandom_range(1, 3))
                    send_byte(8'($urandom), 0, 1'($urandom_range(0, 1)));
            send_frame();
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 6));
        end
        idle(2);

        rd_mode = 1;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        check("final_all_expected_seen", exp_q.size(), 0);
        repeat (20) @(negedge clock);
        check("final_out_empty", out_empty, 1);
        check("final_in_full", in_full, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
